// File: rtl/core_sequencer_if.sv
// core_sequencer_if: run request, memory handshake, decode class flags
// and stage strobes exchanged between the sequencer and the datapath.
interface core_sequencer_if #(
    parameter int COUNTER_WIDTH = 32
) ();

    logic                     enable;
    logic                     mem_ready;
    logic                     load_enable;
    logic                     store_enable;
    logic                     fence_enable;
    logic                     control_instruction;
    logic                     writes_rd;
    logic                     illegal_instruction;

    logic                     pc_enable;
    logic                     decode_valid;
    logic                     execute_valid;
    logic                     read_enable;
    logic                     memory_write_enable;
    logic                     register_file_write_enable;
    logic                     pc_advance;
    logic                     halted;
    logic                     fault;
    logic [COUNTER_WIDTH-1:0] retired_count;
    logic [2:0]               state;

    modport master (
        output enable,
        output mem_ready,
        output load_enable,
        output store_enable,
        output fence_enable,
        output control_instruction,
        output writes_rd,
        output illegal_instruction,
        input  pc_enable,
        input  decode_valid,
        input  execute_valid,
        input  read_enable,
        input  memory_write_enable,
        input  register_file_write_enable,
        input  pc_advance,
        input  halted,
        input  fault,
        input  retired_count,
        input  state
    );

    modport slave (
        input  enable,
        input  mem_ready,
        input  load_enable,
        input  store_enable,
        input  fence_enable,
        input  control_instruction,
        input  writes_rd,
        input  illegal_instruction,
        output pc_enable,
        output decode_valid,
        output execute_valid,
        output read_enable,
        output memory_write_enable,
        output register_file_write_enable,
        output pc_advance,
        output halted,
        output fault,
        output retired_count,
        output state
    );

endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM stepping one RV32I instruction
// through fetch/decode/execute/memory/writeback with memory timeout trap.
module core_sequencer #(
    parameter int MEM_TIMEOUT   = 15,
    parameter int COUNTER_WIDTH = 32
) (
    input logic               clock,
    input logic               reset,
    core_sequencer_if.slave   bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_FAULT     = 3'd6;

    // Counter only needs to reach MEM_TIMEOUT-1; the limit cycle itself
    // is detected combinationally and leads straight to FAULT.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int WAIT_LIM = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIM);
    localparam logic TIMEOUT_ON = (MEM_TIMEOUT > 0);

    logic [2:0]               state_q, state_d;
    logic [WAIT_W-1:0]        wait_q, wait_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;

    logic load_q, load_d;
    logic store_q, store_d;
    logic fence_q, fence_d;
    logic ctrl_q, ctrl_d;
    logic wrd_q, wrd_d;
    logic ill_q, ill_d;

    logic waiting;
    logic expired;
    logic mem_path;
    logic decode_bad;

    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMORY))
                     && !bus.mem_ready;

    assign expired = TIMEOUT_ON && waiting && (wait_q == WAIT_LAST);

    // Fence and control transfers never touch data memory.
    assign mem_path = (load_q | store_q) & ~fence_q & ~ctrl_q;

    assign decode_bad = bus.illegal_instruction
                        | (bus.load_enable & bus.store_enable);

    // Next-state selection; a ready memory beats the timeout limit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                state_d = decode_bad ? S_FAULT : S_EXECUTE;
            end
            S_EXECUTE: begin
                if (ill_q) begin
                    state_d = S_FAULT;
                end else if (mem_path) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (bus.mem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (expired) begin
                    state_d = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                state_d = bus.enable ? S_FETCH : S_IDLE;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Wait counter runs only while memory stalls, otherwise it sits at 0.
    always_comb begin
        wait_d = '0;
        if (TIMEOUT_ON && waiting && !expired) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Class flags are captured once per instruction, in DECODE.
    always_comb begin
        load_d  = load_q;
        store_d = store_q;
        fence_d = fence_q;
        ctrl_d  = ctrl_q;
        wrd_d   = wrd_q;
        ill_d   = ill_q;
        if (state_q == S_DECODE) begin
            load_d  = bus.load_enable;
            store_d = bus.store_enable;
            fence_d = bus.fence_enable;
            ctrl_d  = bus.control_instruction;
            wrd_d   = bus.writes_rd;
            ill_d   = bus.illegal_instruction;
        end
    end

    // Retirement happens in the single WRITEBACK cycle.
    always_comb begin
        count_d = count_q;
        if (state_q == S_WRITEBACK) begin
            count_d = count_q + COUNTER_WIDTH'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            count_q <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            fence_q <= 1'b0;
            ctrl_q  <= 1'b0;
            wrd_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
            load_q  <= load_d;
            store_q <= store_d;
            fence_q <= fence_d;
            ctrl_q  <= ctrl_d;
            wrd_q   <= wrd_d;
            ill_q   <= ill_d;
        end
    end

    // Moore strobes decoded from the registered state and latched flags.
    always_comb begin
        bus.pc_enable                  = (state_q == S_FETCH);
        bus.decode_valid               = (state_q == S_DECODE);
        bus.execute_valid              = (state_q == S_EXECUTE);
        bus.read_enable                = (state_q == S_MEMORY) & load_q;
        bus.memory_write_enable        = (state_q == S_MEMORY) & store_q;
        bus.register_file_write_enable = (state_q == S_WRITEBACK)
                                         & wrd_q & ~store_q & ~fence_q;
        bus.pc_advance                 = (state_q == S_WRITEBACK);
        bus.halted                     = (state_q == S_IDLE)
                                         | (state_q == S_FAULT);
        bus.fault                      = (state_q == S_FAULT);
        bus.retired_count              = count_q;
        bus.state                      = state_q;
    end

endmodule
